uart_tx_fifo: RTL and testbench

Parametrised UART transmitter and successor to the fixed 8N1 transmitter. It accepts words over a valid/ready handshake into an internal FIFO. Each word is serialised LSB-first with a configurable data width, optional parity and 1 or 2 stop bits. Queued words go out back-to-back with no idle gap. It sits between the AES result path and the board TX pin.

---
 rtl/uart_tx_fifo.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a word FIFO: LSB-first frames with configurable data width,
// optional odd/even parity and 1 or 2 stop bits; queued words go out back-to-back.
module uart_tx_fifo #(
  parameter int CLK_PER_TICK = 27,
  parameter int OVERSAMPLE   = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_BITS-1:0]        in_data,
  output logic                        tx,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = (CLK_PER_TICK > 1) ? $clog2(CLK_PER_TICK) : 1;
  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (CLK_PER_TICK < 1 || OVERSAMPLE < 1) begin : g_bad_timing
    $error("uart_tx_fifo: CLK_PER_TICK and OVERSAMPLE must be at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          count_q, count_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic                 tx_q, tx_d;
  logic                 push, pop, clk_end, bit_end, done;

  assign in_ready   = (count_q != (AW+1)'(FIFO_DEPTH));
  assign push       = in_valid && in_ready;
  assign fifo_count = count_q;
  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign tx         = tx_q;
  assign tx_done    = done;

  assign clk_end = (clk_cnt_q == CW'(CLK_PER_TICK - 1));
  assign bit_end = clk_end && (tick_q == TW'(OVERSAMPLE - 1));

  // Counters wrap to zero on every bit boundary, so each state entry starts at zero.
  always_comb begin
    clk_cnt_d = '0;
    tick_d    = '0;
    if (state_q != S_IDLE && !bit_end) begin
      clk_cnt_d = clk_end ? '0 : clk_cnt_q + 1'b1;
      tick_d    = clk_end ? tick_q + 1'b1 : tick_q;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    pop     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE:  if (count_q != '0) pop = 1'b1;
      S_START: if (bit_end) begin
        state_d = S_DATA;
        bit_d   = '0;
      end
      S_DATA:  if (bit_end) begin
        shift_d = shift_q >> 1;
        if (bit_q == BW'(DATA_BITS - 1)) begin
          state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          stop_d  = 1'b0;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      S_PARITY: if (bit_end) begin
        state_d = S_STOP;
        stop_d  = 1'b0;
      end
      S_STOP:  if (bit_end) begin
        if (stop_q == 1'(STOP_BITS - 1)) begin
          done = 1'b1;
          if (count_q != '0) pop = 1'b1;
          else               state_d = S_IDLE;
        end else begin
          stop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Loading the head word doubles as the FIFO pop.
    if (pop) begin
      state_d = S_START;
      shift_d = mem_q[rd_ptr_q];
      par_d   = (PARITY == 1) ? ~^mem_q[rd_ptr_q] : ^mem_q[rd_ptr_q];
      bit_d   = '0;
    end
  end

  always_comb begin
    unique case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      bit_q     <= '0;
      stop_q    <= 1'b0;
      clk_cnt_q <= '0;
      tick_q    <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q   <= count_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      bit_q     <= bit_d;
      stop_q    <= stop_d;
      clk_cnt_q <= clk_cnt_d;
      tick_q    <= tick_d;
      tx_q      <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations (8N1, 7E1, 7O1, 5N2) checked cycle by cycle
// against a frame-level line model built from queued words.
module tb_uart_tx_fifo;
  localparam int CPT   = 2;
  localparam int OS    = 4;
  localparam int BC    = CPT * OS;
  localparam int DEPTH = 4;
  localparam int NI    = 4;
  localparam int LIMIT = 2000;

  int DB  [NI] = '{8, 7, 7, 5};
  int PAR [NI] = '{0, 2, 1, 0};
  int SB  [NI] = '{1, 1, 1, 2};

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NI-1:0]         iv;
  logic [NI-1:0][8:0]    id;
  wire  [NI-1:0]         rdy, txv, bsy, dn;
  wire  [NI-1:0][2:0]    cnt;

  int errs = 0;
  int checks = 0;

  logic [8:0] src [$];
  bit         exp_q [$];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_PER_TICK(CPT), .OVERSAMPLE(OS)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(rdy[0]), .in_data(id[0][7:0]),
    .tx(txv[0]), .busy(bsy[0]), .tx_done(dn[0]), .fifo_count(cnt[0]));
  uart_tx_fifo #(.CLK_PER_TICK(CPT), .OVERSAMPLE(OS), .DATA_BITS(7), .PARITY(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(rdy[1]), .in_data(id[1][6:0]),
    .tx(txv[1]), .busy(bsy[1]), .tx_done(dn[1]), .fifo_count(cnt[1]));
  uart_tx_fifo #(.CLK_PER_TICK(CPT), .OVERSAMPLE(OS), .DATA_BITS(7), .PARITY(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(rdy[2]), .in_data(id[2][6:0]),
    .tx(txv[2]), .busy(bsy[2]), .tx_done(dn[2]), .fifo_count(cnt[2]));
  uart_tx_fifo #(.CLK_PER_TICK(CPT), .OVERSAMPLE(OS), .DATA_BITS(5), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(rdy[3]), .in_data(id[3][4:0]),
    .tx(txv[3]), .busy(bsy[3]), .tx_done(dn[3]), .fifo_count(cnt[3]));

  // Line levels of one frame, each held for one bit time.
  function automatic void add_frame(int s, logic [8:0] w);
    bit         lv [$];
    logic [8:0] m;
    int         ones;
    m    = w & 9'((1 << DB[s]) - 1);
    ones = $countones(m);
    lv.push_back(1'b0);
    for (int i = 0; i < DB[s]; i++) lv.push_back(m[i]);
    if (PAR[s] == 2) lv.push_back(bit'(ones % 2));
    if (PAR[s] == 1) lv.push_back(bit'(1 - ones % 2));
    for (int i = 0; i < SB[s]; i++) lv.push_back(1'b1);
    foreach (lv[i]) for (int k = 0; k < BC; k++) exp_q.push_back(lv[i]);
  endfunction

  // Feeds src into instance s and checks every cycle until the line is idle again.
  task automatic stream(input int s, input bit hold, input string nm);
    logic [8:0] pend [$];
    int  cyc;
    bit  v, acc, active, lvl, dexp, bexp;
    cyc = 0;
    exp_q.delete();
    while ((src.size() > 0 || pend.size() > 0 || exp_q.size() > 0) && cyc < LIMIT) begin
      v     = (src.size() > 0) && (hold || $urandom_range(0, 2) != 0);
      iv[s] = v;
      id[s] = v ? src[0] : 9'($urandom);
      acc   = v && (pend.size() < DEPTH);
      @(posedge clk); #1;
      cyc++;
      if (exp_q.size() == 0 && pend.size() > 0) add_frame(s, pend.pop_front());
      if (acc) pend.push_back(src.pop_front());
      active = exp_q.size() > 0;
      if (active) begin
        lvl  = exp_q.pop_front();
        dexp = (exp_q.size() == 0);
      end else begin
        lvl  = 1'b1;
        dexp = 1'b0;
      end
      bexp = active || pend.size() > 0;
      checks += 5;
      if (txv[s] !== lvl) begin
        errs++; $display("FAIL %s tx cyc=%0d got=%b want=%b", nm, cyc, txv[s], lvl);
      end
      if (dn[s] !== dexp) begin
        errs++; $display("FAIL %s tx_done cyc=%0d got=%b want=%b", nm, cyc, dn[s], dexp);
      end
      if (bsy[s] !== bexp) begin
        errs++; $display("FAIL %s busy cyc=%0d got=%b want=%b", nm, cyc, bsy[s], bexp);
      end
      if (cnt[s] !== 3'(pend.size())) begin
        errs++; $display("FAIL %s fifo_count cyc=%0d got=%0d want=%0d", nm, cyc, cnt[s], pend.size());
      end
      if (rdy[s] !== (pend.size() < DEPTH)) begin
        errs++; $display("FAIL %s in_ready cyc=%0d got=%b want=%b", nm, cyc, rdy[s], pend.size() < DEPTH);
      end
    end
    iv[s] = 1'b0;
    if (cyc >= LIMIT) begin
      errs++; checks++;
      $display("FAIL %s timeout after %0d cycles", nm, cyc);
      src.delete();
    end
    @(posedge clk); #1;
    checks += 2;
    if (txv[s] !== 1'b1) begin errs++; $display("FAIL %s idle_tx got=%b want=1", nm, txv[s]); end
    if (bsy[s] !== 1'b0) begin errs++; $display("FAIL %s idle_busy got=%b want=0", nm, bsy[s]); end
  endtask

  task automatic test_reset();
    #12;
    for (int s = 0; s < NI; s++) begin
      checks += 5;
      if (txv[s] !== 1'b1) begin errs++; $display("FAIL reset_tx[%0d] got=%b want=1", s, txv[s]); end
      if (bsy[s] !== 1'b0) begin errs++; $display("FAIL reset_busy[%0d] got=%b want=0", s, bsy[s]); end
      if (dn[s]  !== 1'b0) begin errs++; $display("FAIL reset_done[%0d] got=%b want=0", s, dn[s]); end
      if (cnt[s] !== 3'd0) begin errs++; $display("FAIL reset_count[%0d] got=%0d want=0", s, cnt[s]); end
      if (rdy[s] !== 1'b1) begin errs++; $display("FAIL reset_ready[%0d] got=%b want=1", s, rdy[s]); end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_8n1();
    src = '{9'h055};
    stream(0, 1'b1, "8n1_0x55");
  endtask

  task automatic test_back_to_back();
    src = '{9'h0A5, 9'h03C, 9'h0FF, 9'h000, 9'h081};
    stream(0, 1'b1, "b2b");
  endtask

  task automatic test_parity();
    src = '{9'h007};
    stream(1, 1'b1, "even7_0x07");
    src = '{9'h007};
    stream(2, 1'b1, "odd7_0x07");
    src = '{9'h05A, 9'h07F};
    stream(1, 1'b1, "even7_pair");
  endtask

  task automatic test_two_stop();
    src = '{9'h01F, 9'h000};
    stream(3, 1'b1, "5n2_pair");
  endtask

  task automatic test_full_pushpop();
    src = '{9'h011, 9'h022, 9'h033, 9'h044, 9'h055, 9'h066};
    stream(0, 1'b1, "full_pushpop");
  endtask

  task automatic test_reset_midframe();
    logic [8:0] w [3];
    w = '{9'h0F0, 9'h033, 9'h0CC};
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1'b1; id[0] = w[i];
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    repeat (27) @(posedge clk);
    #2;
    checks += 3;
    if (cnt[0] !== 3'd2) begin errs++; $display("FAIL midframe_count got=%0d want=2", cnt[0]); end
    if (bsy[0] !== 1'b1) begin errs++; $display("FAIL midframe_busy got=%b want=1", bsy[0]); end
    if (txv[0] !== 1'b0) begin errs++; $display("FAIL midframe_tx got=%b want=0", txv[0]); end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (txv[0] !== 1'b1) begin errs++; $display("FAIL async_reset_tx got=%b want=1", txv[0]); end
    if (bsy[0] !== 1'b0) begin errs++; $display("FAIL async_reset_busy got=%b want=0", bsy[0]); end
    if (cnt[0] !== 3'd0) begin errs++; $display("FAIL async_reset_count got=%0d want=0", cnt[0]); end
    if (rdy[0] !== 1'b1) begin errs++; $display("FAIL async_reset_ready got=%b want=1", rdy[0]); end
    @(posedge clk); @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    src = '{9'h042};
    stream(0, 1'b1, "post_reset_0x42");
  endtask

  task automatic test_random();
    for (int s = 0; s < NI; s++) begin
      for (int i = 0; i < 6; i++) src.push_back(9'($urandom));
      stream(s, 1'b0, $sformatf("random_u%0d", s));
    end
  endtask

  initial begin
    iv = '0;
    id = '0;
    test_reset();
    test_8n1();
    test_back_to_back();
    test_parity();
    test_two_stop();
    test_full_pushpop();
    test_reset_midframe();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
